conv_window_sequencer: RTL and testbench

- Parametrised successor to the fixed-size, hand-staggered row-enable scheme used to feed the systolic MAC array.
- Generates im2col-ordered image read addresses for a K x K convolution over an H x W image.
- Drives per-row read enables, skewed by a programmable stagger, and one done pulse per job.
- Sits between the image buffer / row FIFOs and the ARRAY_SIZE-row systolic array, on s_clk.

---
 rtl/conv_window_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Generates im2col-ordered read addresses for a K x K convolution over an
//   H x W image held in the image buffer, plus per-row read enables for the
//   systolic MAC array, each row skewed by STAGGER cycles from the previous.
//
//   Optional build macro: CONV_STRIDE_EN (adds the stride input).
//
// Ports:
//   s_clk            sole clock
//   reset            synchronous, active-high reset
//   start            one-cycle job request, sampled only when idle
//   stall            freezes counters, address output and stagger pipeline
//   stride           (CONV_STRIDE_EN only) window step S, latched on start
//   initial_address  image base address, latched on start
//   image_height     H, latched on start
//   image_width      W, latched on start
//   weight_size      K (kernel is K x K), latched on start
//   rd_addr          image read address
//   rd_valid         rd_addr valid this cycle
//   r_en             staggered per-row read enables (r_en[0] == rd_valid)
//   busy             high whenever a job is in progress
//   done             one-cycle completion pulse
//   err              configuration error, held until the next accepted start
module conv_window_sequencer #(
    parameter int ARRAY_SIZE = 9,
    parameter int DIM_W      = 8,
    parameter int ADDR_W     = 20,
    parameter int STAGGER    = 1
) (
    input  logic                  s_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
`ifdef CONV_STRIDE_EN
    input  logic [DIM_W-1:0]      stride,
`endif
    input  logic [ADDR_W-1:0]     initial_address,
    input  logic [DIM_W-1:0]      image_height,
    input  logic [DIM_W-1:0]      image_width,
    input  logic [DIM_W-1:0]      weight_size,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [ARRAY_SIZE-1:0] r_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    localparam int unsigned DRAIN_CYC = (ARRAY_SIZE - 1) * STAGGER;
    localparam int unsigned SR_LEN    = (DRAIN_CYC > 0) ? DRAIN_CYC : 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  h_q, w_q, k_q, s_q;
    logic [DIM_W-1:0]  wk_diff, hk_diff;
    logic [DIM_W-1:0]  row_pos, col_pos, ki, kj;
    logic [ADDR_W-1:0] line_base;   // address of (window row, col 0)
    logic [ADDR_W-1:0] win_base;    // address of current window top-left
    logic [ADDR_W-1:0] row_base;    // address of (window row + ki, window col)
    logic [ADDR_W-1:0] row_step;    // S image rows in address units
    logic [31:0]       drain_cnt;
    logic [SR_LEN-1:0] sr;

    logic [ADDR_W-1:0] w_ext, s_ext;
    logic [DIM_W-1:0]  k_m1;
    logic              cfg_bad, kj_last, ki_last, col_last, row_last, at_last;

    assign w_ext = {{(ADDR_W-DIM_W){1'b0}}, w_q};
    assign s_ext = {{(ADDR_W-DIM_W){1'b0}}, s_q};
    assign k_m1  = k_q - DIM_W'(1);

`ifdef CONV_STRIDE_EN
    assign cfg_bad = (k_q == '0) || (k_q > h_q) || (k_q > w_q) ||
                     (32'(k_q) > 32'(ARRAY_SIZE)) || (s_q == '0);
`else
    assign s_q      = DIM_W'(1);
    assign row_step = w_ext;
    assign cfg_bad  = (k_q == '0) || (k_q > h_q) || (k_q > w_q) ||
                      (32'(k_q) > 32'(ARRAY_SIZE));
`endif

    // Window position limits replace OH/OW counts: a further window exists
    // only while pos + S <= H-K (or W-K). With S=1 this is pos == OH-1 / OW-1,
    // and it avoids a divider for the strided build.
    assign kj_last  = (kj == k_m1);
    assign ki_last  = (ki == k_m1);
    assign col_last = ({1'b0, col_pos} + {1'b0, s_q}) > {1'b0, wk_diff};
    assign row_last = ({1'b0, row_pos} + {1'b0, s_q}) > {1'b0, hk_diff};
    assign at_last  = kj_last && ki_last && col_last && row_last;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    always_ff @(posedge s_clk) begin
        if (reset) begin
            state     <= IDLE;
            base_q    <= '0;
            h_q       <= '0;
            w_q       <= '0;
            k_q       <= '0;
            wk_diff   <= '0;
            hk_diff   <= '0;
            row_pos   <= '0;
            col_pos   <= '0;
            ki        <= '0;
            kj        <= '0;
            line_base <= '0;
            win_base  <= '0;
            row_base  <= '0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            drain_cnt <= '0;
`ifdef CONV_STRIDE_EN
            s_q       <= '0;
            row_step  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= initial_address;
                        h_q    <= image_height;
                        w_q    <= image_width;
                        k_q    <= weight_size;
`ifdef CONV_STRIDE_EN
                        s_q    <= stride;
`endif
                        err    <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_bad) begin
                        err   <= 1'b1;
                        state <= FIN;
                    end else begin
                        wk_diff   <= w_q - k_q;
                        hk_diff   <= h_q - k_q;
                        row_pos   <= '0;
                        col_pos   <= '0;
                        ki        <= '0;
                        kj        <= '0;
                        line_base <= base_q;
                        win_base  <= base_q;
                        row_base  <= base_q;
                        rd_addr   <= base_q;
                        rd_valid  <= 1'b1;
`ifdef CONV_STRIDE_EN
                        // One-off configuration product; the address path
                        // itself only ever adds.
                        row_step  <= w_ext * s_ext;
`endif
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (at_last) begin
                            rd_valid  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= (DRAIN_CYC == 0) ? FIN : DRAIN;
                        end else if (!kj_last) begin
                            kj      <= kj + DIM_W'(1);
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end else if (!ki_last) begin
                            kj       <= '0;
                            ki       <= ki + DIM_W'(1);
                            row_base <= row_base + w_ext;
                            rd_addr  <= row_base + w_ext;
                        end else if (!col_last) begin
                            kj       <= '0;
                            ki       <= '0;
                            col_pos  <= col_pos + s_q;
                            win_base <= win_base + s_ext;
                            row_base <= win_base + s_ext;
                            rd_addr  <= win_base + s_ext;
                        end else begin
                            kj        <= '0;
                            ki        <= '0;
                            col_pos   <= '0;
                            row_pos   <= row_pos + s_q;
                            line_base <= line_base + row_step;
                            win_base  <= line_base + row_step;
                            row_base  <= line_base + row_step;
                            rd_addr   <= line_base + row_step;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == 32'(DRAIN_CYC - 1)) begin
                            state <= FIN;
                        end else begin
                            drain_cnt <= drain_cnt + 32'd1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // sr[j] holds rd_valid delayed by j+1 non-stalled cycles.
    always_ff @(posedge s_clk) begin
        if (reset) begin
            sr <= '0;
        end else if (!stall) begin
            sr <= (sr << 1) | SR_LEN'(rd_valid);
        end
    end

    always_comb begin
        r_en    = '0;
        r_en[0] = rd_valid;
        for (int unsigned i = 1; i < ARRAY_SIZE; i++) begin
            r_en[i] = sr[i*STAGGER-1];
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer
//   Scoreboard bench for conv_window_sequencer (ARRAY_SIZE=9, STAGGER=1).
//   Expected addresses are generated by a direct im2col model and queued at
//   job start; each valid DUT address pops and compares one entry. Timing of
//   first/last address, r_en skew, done and err is checked per job.
//   Build with CONV_STRIDE_EN defined to add the strided jobs.
module tb_conv_window_sequencer;

    localparam int AS = 9;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int ST = 1;

    logic          clk = 1'b0;
    logic          reset, start, stall;
    logic [DW-1:0] stride;
    logic [AW-1:0] initial_address;
    logic [DW-1:0] image_height, image_width, weight_size;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [AS-1:0] r_en;
    logic          busy, done, err;

    conv_window_sequencer #(
        .ARRAY_SIZE (AS),
        .DIM_W      (DW),
        .ADDR_W     (AW),
        .STAGGER    (ST)
    ) dut (
        .s_clk           (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
`ifdef CONV_STRIDE_EN
        .stride          (stride),
`endif
        .initial_address (initial_address),
        .image_height    (image_height),
        .image_width     (image_width),
        .weight_size     (weight_size),
        .rd_addr         (rd_addr),
        .rd_valid        (rd_valid),
        .r_en            (r_en),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ss/sl: stall raised at relative cycle ss for sl cycles (sl=0: none).
    task automatic run_job(input logic [AW-1:0] init, input int h, input int w,
                           input int k, input int s, input int ss, input int sl);
        int oh, ow, n, d, t0, rel, nvalid;
        int first_v, last_v, ren8_first, ren8_last, ren4_first, done_rel;
        bit bad, frozen, ren_any;
        logic [AW-1:0] e, last_exp;
        bad = (k == 0) || (k > h) || (k > w) || (k > AS) || (s == 0);
        exp_q.delete();
        n = 0;
        if (!bad) begin
            oh = (h - k) / s + 1;
            ow = (w - k) / s + 1;
            for (int r = 0; r < oh; r++)
                for (int c = 0; c < ow; c++)
                    for (int ki = 0; ki < k; ki++)
                        for (int kj = 0; kj < k; kj++) begin
                            e = init + AW'((r*s + ki) * w + c*s + kj);
                            exp_q.push_back(e);
                        end
            n = oh * ow * k * k;
        end
        d = bad ? 0 : (AS - 1) * ST;
        nvalid = 0; first_v = -1; last_v = -1; ren8_first = -1; ren8_last = -1;
        ren4_first = -1; done_rel = -1; ren_any = 0; last_exp = '0;

        @(negedge clk);
        initial_address = init;
        image_height    = DW'(h);
        image_width     = DW'(w);
        weight_size     = DW'(k);
        stride          = DW'(s);
        start           = 1'b1;
        t0              = cyc;

        for (int i = 0; i < 400 && done_rel < 0; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            frozen = (sl > 0) && (rel >= ss + 1) && (rel <= ss + sl);
            if (rel == 1) chk("busy_load", busy, 1);
            if (rd_valid) begin
                if (first_v < 0) first_v = rel;
                last_v = rel;
                if (frozen) begin
                    chk("hold_addr", rd_addr, last_exp);
                end else if (exp_q.size() == 0) begin
                    chk("extra_valid", rd_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", rd_addr, e);
                    last_exp = e;
                    nvalid++;
                end
            end
            if (|r_en) ren_any = 1;
            if (r_en[8]) begin
                if (ren8_first < 0) ren8_first = rel;
                ren8_last = rel;
            end
            if (r_en[4] && ren4_first < 0) ren4_first = rel;
            if (done) done_rel = rel;
            // drive inputs for the next edge
            if (rel == 1) start = 1'b0;
            if (rel == 5) begin
                start       = 1'b1;
                weight_size = DW'(1);
                image_width = DW'(w + 2);
            end
            if (rel == 6) start = 1'b0;
            if (sl > 0 && rel == ss) stall = 1'b1;
            if (sl > 0 && rel == ss + sl) stall = 1'b0;
        end
        if (done_rel < 0) chk("timeout", done, 1);

        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("err", err, bad);
        chk("leftover", exp_q.size(), 0);
        chk("n_valid", nvalid, n);
        if (!bad) begin
            chk("first_valid", first_v, 2);
            chk("last_valid", last_v, 1 + n + sl);
            chk("ren4_rise", ren4_first, 2 + 4 * ST);
            chk("ren8_rise", ren8_first, 2 + 8 * ST);
            chk("ren8_fall", ren8_last, 1 + n + sl + 8 * ST);
            chk("done_time", done_rel, 2 + n + d + sl);
        end else begin
            chk("err_no_valid", first_v, -1);
            chk("err_no_ren", ren_any, 0);
            chk("err_done_time", done_rel, 2);
        end
    endtask

    task automatic reset_mid_job();
        int t0, rel, done_cnt, valid_cnt;
        @(negedge clk);
        initial_address = '0;
        image_height    = DW'(5);
        image_width     = DW'(5);
        weight_size     = DW'(3);
        stride          = DW'(1);
        start           = 1'b1;
        t0              = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rel = cyc - t0;
        chk("pre_reset_valid", rd_valid, (rel >= 2) ? 1 : 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_addr", rd_addr, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ren", r_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        done_cnt = 0;
        valid_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rd_valid || busy) valid_cnt++;
        end
        chk("no_done_after_reset", done_cnt, 0);
        chk("idle_after_reset", valid_cnt, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; stride = DW'(1);
        initial_address = '0; image_height = '0; image_width = '0; weight_size = '0;
        repeat (3) @(negedge clk);
        chk("reset_addr", rd_addr, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_ren", r_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        run_job(20'h00000, 5, 5, 3, 1, 0, 0);
        run_job(20'hFFFF0, 5, 5, 3, 1, 0, 0);
        run_job(20'h00000, 3, 5, 4, 1, 0, 0);
        run_job(20'h00000, 5, 5, 3, 1, 20, 5);
        reset_mid_job();
        run_job(20'h00000, 5, 5, 3, 1, 0, 0);
        run_job(20'h00100, 3, 3, 3, 1, 0, 0);
        run_job(20'h00000, 12, 12, 10, 1, 0, 0);
        run_job(20'h00000, 5, 5, 0, 1, 0, 0);
        run_job(20'h00003, 4, 6, 2, 1, 0, 0);
`ifdef CONV_STRIDE_EN
        run_job(20'h00000, 5, 5, 3, 2, 0, 0);
        run_job(20'h00040, 7, 6, 2, 3, 0, 0);
        run_job(20'h00000, 5, 5, 3, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
